// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package sync_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of an index into 0..v-1, never narrower than one bit.
    function automatic int idx_width(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

    localparam int N_REQ_DEF     = 4;
    localparam int MAX_BURST_DEF = 4;
    localparam int IDX_W         = idx_width(N_REQ_DEF);
    localparam int BEAT_W        = idx_width(MAX_BURST_DEF + 1);

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: the first set request at or after
// ptr (modulo N) wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from farthest to nearest so the request closest to ptr wins last.
    always_comb begin
        int k;
        k     = 0;
        gnt   = '0;
        idx   = '0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[k]) idx = IW'(k);
        end
        if (valid) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write arbiter with locked bursts and credit-based occupancy
// tracking in front of a synchronous FIFO write port.
//
//  state | meaning
//  IDLE  | round-robin among all requesters starting at rr_ptr
//  BURST | only the locked owner is eligible, up to MAX_BURST beats
module sync_fifo_wr_arbiter
    import sync_fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 16,
    parameter int MAX_BURST  = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ-1:0]            lock_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic                        fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]       fifo_wdata_o,
    input  logic                        fifo_full_i,
    input  logic                        fifo_rd_en_i,
    input  logic                        fifo_empty_i,
    output logic [CNT_W-1:0]            occupancy_o,
    output logic                        busy_o,
    output logic [$clog2(N_REQ)-1:0]    owner_o
);

    localparam int IW = idx_width(N_REQ);
    localparam int BW = idx_width(MAX_BURST + 1);

    arb_state_t          state, state_nxt;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       owner;
    logic [BW-1:0]       beat_cnt;
    logic [CNT_W-1:0]    occ;

    logic [N_REQ-1:0]    pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;

    logic [N_REQ-1:0]    gnt_vec;
    logic [IW-1:0]       gnt_idx;
    logic                grant;
    logic                space;
    logic                pop;
    logic                last_beat;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (req_i),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A full flag that disagrees with the credit count still blocks grants.
    assign space     = (occ < CNT_W'(DEPTH)) && !fifo_full_i;
    assign pop       = fifo_rd_en_i && !fifo_empty_i && (occ != '0);
    assign grant     = |gnt_vec;
    assign last_beat = (beat_cnt + BW'(1)) == BW'(MAX_BURST);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant && lock_i[pick_idx] && (MAX_BURST > 1)) state_nxt = BURST;
            end
            BURST: begin
                if (!req_i[owner])                              state_nxt = IDLE;
                else if (grant && (last_beat || !lock_i[owner])) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant decode; held at zero while reset is asserted.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        if (rst_ni) begin
            case (state)
                IDLE: begin
                    if (space && pick_valid) begin
                        gnt_vec = pick_gnt;
                        gnt_idx = pick_idx;
                    end
                end
                BURST: begin
                    if (space && req_i[owner]) begin
                        gnt_vec[owner] = 1'b1;
                        gnt_idx        = owner;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointer, burst bookkeeping, credit counter and registered write port.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr       <= '0;
            owner        <= '0;
            beat_cnt     <= '0;
            occ          <= '0;
            fifo_wr_en_o <= 1'b0;
            fifo_wdata_o <= '0;
        end else begin
            fifo_wr_en_o <= grant;
            if (grant) fifo_wdata_o <= wdata_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

            if (state == IDLE && grant) begin
                rr_ptr <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
                if (state_nxt == BURST) begin
                    owner    <= pick_idx;
                    beat_cnt <= BW'(1);
                end
            end else if (state == BURST) begin
                if (state_nxt == IDLE)  beat_cnt <= '0;
                else if (grant)         beat_cnt <= beat_cnt + BW'(1);
            end

            case ({grant, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign gnt_o       = gnt_vec;
    assign occupancy_o = occ;
    assign busy_o      = (state == BURST);
    assign owner_o     = owner;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed bench for the FIFO write arbiter: grants are checked at drive
// time, written words are checked by a monitor against a scoreboard queue.
module tb_sync_fifo_wr_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 10;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic [N_REQ-1:0]    req_i = '0;
    logic [N_REQ-1:0]    lock_i = '0;
    logic [N_REQ*DW-1:0] wdata_i = '0;
    logic [N_REQ-1:0]    gnt_o;
    logic                fifo_wr_en_o;
    logic [DW-1:0]       fifo_wdata_o;
    logic                fifo_full_i = 1'b0;
    logic                fifo_rd_en_i = 1'b0;
    logic                fifo_empty_i = 1'b0;
    logic [CW-1:0]       occupancy_o;
    logic                busy_o;
    logic [1:0]          owner_o;

    int n_cmp = 0;
    int n_bad = 0;
    int tag   = 0;
    logic [DW-1:0] exp_q[$];

    sync_fifo_wr_arbiter #(
        .N_REQ(N_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .lock_i       (lock_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_wdata_o (fifo_wdata_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_rd_en_i (fifo_rd_en_i),
        .fifo_empty_i (fifo_empty_i),
        .occupancy_o  (occupancy_o),
        .busy_o       (busy_o),
        .owner_o      (owner_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every registered write must match the oldest expected word.
    always @(negedge clk_i) begin
        if (fifo_wr_en_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got data %0d expected no write at %0t", fifo_wdata_o, $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (fifo_wdata_o !== e) begin
                    n_bad++;
                    $display("FAIL wr_data: got %0d expected %0d at %0t", fifo_wdata_o, e, $time);
                end
            end
        end
    end

    // One clock: drive inputs on the falling edge, check the grant, record
    // the expected write, then return just after the rising edge.
    task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                       input logic rd, input logic full, input logic [3:0] exp_gnt);
        @(negedge clk_i);
        tag++;
        rst_ni       = rst;
        req_i        = req;
        lock_i       = lock;
        fifo_rd_en_i = rd;
        fifo_full_i  = full;
        for (int k = 0; k < N_REQ; k++)
            wdata_i[k*DW +: DW] = DW'({tag[7:0], 2'(k)});
        #1;
        chk("gnt", int'(gnt_o), int'(exp_gnt));
        for (int k = 0; k < N_REQ; k++)
            if (exp_gnt[k]) exp_q.push_back(DW'({tag[7:0], 2'(k)}));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state, with requests pending that must not be granted.
        cyc(0, 4'hF, 4'h0, 0, 0, 4'h0);
        cyc(0, 4'hF, 4'h0, 0, 0, 4'h0);
        chk("rst_occ", int'(occupancy_o), 0);
        chk("rst_wr_en", int'(fifo_wr_en_o), 0);
        chk("rst_wdata", int'(fifo_wdata_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_owner", int'(owner_o), 0);

        // 1: fill with plain round-robin grants.
        for (int i = 0; i < 16; i++)
            cyc(1, 4'hF, 4'h0, 0, 0, 4'(1 << (i % 4)));
        chk("t1_last_wr_en", int'(fifo_wr_en_o), 1);
        cyc(1, 4'hF, 4'h0, 0, 0, 4'h0);
        chk("t1_occ_full", int'(occupancy_o), 16);
        chk("t1_wr_en_off", int'(fifo_wr_en_o), 0);

        // 2: one pop frees one credit, which goes to requester 0.
        cyc(1, 4'hF, 4'h0, 1, 0, 4'h0);
        chk("t2_occ_pop", int'(occupancy_o), 15);
        cyc(1, 4'hF, 4'h0, 0, 0, 4'h1);
        chk("t2_occ_refill", int'(occupancy_o), 16);

        // Drain, then a pop at zero must not underflow.
        for (int i = 0; i < 16; i++)
            cyc(1, 4'h0, 4'h0, 1, 0, 4'h0);
        chk("drain_occ", int'(occupancy_o), 0);
        cyc(1, 4'h0, 4'h0, 1, 0, 4'h0);
        chk("underflow_occ", int'(occupancy_o), 0);

        // Full flag raised while credits remain: grants withheld.
        cyc(1, 4'hF, 4'h0, 0, 1, 4'h0);

        // 3: bring rr_ptr to 0, then a locked burst by requester 0.
        cyc(1, 4'h8, 4'h0, 0, 0, 4'h8);
        cyc(1, 4'hF, 4'h1, 0, 0, 4'h1);
        chk("t3_busy_b1", int'(busy_o), 1);
        chk("t3_owner", int'(owner_o), 0);
        cyc(1, 4'hF, 4'h1, 0, 0, 4'h1);
        chk("t3_busy_b2", int'(busy_o), 1);
        cyc(1, 4'hF, 4'h1, 0, 0, 4'h1);
        chk("t3_busy_b3", int'(busy_o), 1);
        cyc(1, 4'hF, 4'h1, 0, 0, 4'h1);
        chk("t3_busy_b4", int'(busy_o), 0);
        cyc(1, 4'hF, 4'h1, 0, 0, 4'h2);
        chk("t3_busy_after", int'(busy_o), 0);
        chk("t3_occ", int'(occupancy_o), 6);

        // 4: reach 8, then push and pop together.
        cyc(1, 4'hF, 4'h0, 0, 0, 4'h4);
        cyc(1, 4'hF, 4'h0, 0, 0, 4'h8);
        chk("t4_occ8", int'(occupancy_o), 8);
        cyc(1, 4'hF, 4'h0, 1, 0, 4'h1);
        chk("t4_occ_same", int'(occupancy_o), 8);

        // 5: reset in the middle of a burst by requester 1.
        cyc(1, 4'hF, 4'h2, 0, 0, 4'h2);
        chk("t5_busy", int'(busy_o), 1);
        chk("t5_owner", int'(owner_o), 1);
        cyc(1, 4'hF, 4'h2, 0, 0, 4'h2);
        cyc(0, 4'hF, 4'h2, 0, 0, 4'h0);
        chk("t5_wr_en", int'(fifo_wr_en_o), 0);
        chk("t5_occ", int'(occupancy_o), 0);
        chk("t5_busy_rst", int'(busy_o), 0);
        cyc(1, 4'hF, 4'h0, 0, 0, 4'h1);

        // 6: owner 1 drops its request after beat 2.
        cyc(1, 4'hF, 4'h2, 0, 0, 4'h2);
        cyc(1, 4'hF, 4'h2, 0, 0, 4'h2);
        chk("t6_busy_mid", int'(busy_o), 1);
        cyc(1, 4'hD, 4'h2, 0, 0, 4'h0);
        chk("t6_busy_exit", int'(busy_o), 0);
        cyc(1, 4'hD, 4'h0, 0, 0, 4'h4);
        chk("t6_occ", int'(occupancy_o), 4);

        cyc(1, 4'h0, 4'h0, 0, 0, 4'h0);
        cyc(1, 4'h0, 4'h0, 0, 0, 4'h0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
